img_window_feeder: RTL and testbench

//  Streaming 4x4 window generator, upstream of the 3x3 filter accelerator.

---
 rtl/img_window_feeder.sv | 172 +++++++++++++++++
 tb/tb_img_window_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/img_window_feeder.sv
// Streaming 4x4 window generator: buffers the last three image rows and emits
// stride-2 4x4 windows as four packed 32-bit row words.
module img_window_feeder #(
   parameter int IMG_W = 16,
   parameter int IMG_H = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [7:0]  pix_data,
   input  logic        pix_sof,
   output logic        win_valid,
   input  logic        win_ready,
   output logic [31:0] win_b0,
   output logic [31:0] win_b1,
   output logic [31:0] win_b2,
   output logic [31:0] win_b3,
   output logic [7:0]  win_x,
   output logic [7:0]  win_y,
   output logic        frame_done
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;
   localparam logic [7:0] X_LAST    = 8'(IMG_W - 1);
   localparam logic [7:0] Y_LAST    = 8'(IMG_H - 1);

   logic [0:0]    state_q, state_d;
   logic [7:0]    x_q, x_d, y_q, y_d;
   logic          frame_done_q, frame_done_d;
   logic          win_valid_q, win_valid_d;
   logic [7:0]    win_x_q, win_x_d, win_y_q, win_y_d;
   logic [31:0]   win_b_q [4];
   logic [31:0]   win_b_d [4];
   logic [23:0]   col_q [4];
   logic [23:0]   col_d [4];

   logic [7:0]    lb0_q [IMG_W];
   logic [7:0]    lb1_q [IMG_W];
   logic [7:0]    lb2_q [IMG_W];

   logic          pix_ready_s, acc_s, take_s, emit_s;
   logic [7:0]    wx_s, wy_s;
   logic [XW-1:0] idx_s;
   logic [7:0]    lb_rd_s [4];
   logic [31:0]   word_s [4];

   assign idx_s      = wx_s[XW-1:0];
   assign lb_rd_s[0] = lb0_q[idx_s];
   assign lb_rd_s[1] = lb1_q[idx_s];
   assign lb_rd_s[2] = lb2_q[idx_s];
   assign lb_rd_s[3] = pix_data;

   // Pixel position tracking; a sof pixel always restarts the frame at (0,0).
   always_comb begin
      pix_ready_s  = ~win_valid_q | win_ready;
      acc_s        = pix_valid & pix_ready_s;
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      take_s       = 1'b0;
      wx_s         = x_q;
      wy_s         = y_q;
      frame_done_d = 1'b0;
      if (acc_s && pix_sof) begin
         take_s  = 1'b1;
         wx_s    = 8'd0;
         wy_s    = 8'd0;
         x_d     = 8'd1;
         y_d     = 8'd0;
         state_d = ST_ACTIVE;
      end else begin
         case (state_q)
            ST_ACTIVE: begin
               if (acc_s) begin
                  take_s = 1'b1;
                  if (x_q == X_LAST) begin
                     x_d = 8'd0;
                     if (y_q == Y_LAST) begin
                        y_d          = 8'd0;
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                     end else begin
                        y_d = y_q + 8'd1;
                     end
                  end else begin
                     x_d = x_q + 8'd1;
                  end
               end else begin
                  take_s = 1'b0;
               end
            end
            ST_IDLE: begin
               take_s = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Column shift register and window output register next-state.
   always_comb begin
      emit_s = take_s & (wx_s >= 8'd3) & (wy_s >= 8'd3) & wx_s[0] & wy_s[0];
      for (int k = 0; k < 4; k++) begin
         word_s[k]  = {col_q[k], lb_rd_s[k]};
         col_d[k]   = take_s ? word_s[k][23:0] : col_q[k];
         win_b_d[k] = emit_s ? word_s[k] : win_b_q[k];
      end
      if (emit_s) begin
         win_valid_d = 1'b1;
         win_x_d     = (wx_s - 8'd3) >> 1;
         win_y_d     = (wy_s - 8'd3) >> 1;
      end else begin
         win_valid_d = win_valid_q & ~win_ready;
         win_x_d     = win_x_q;
         win_y_d     = win_y_q;
      end
   end

   // Control and output state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         x_q          <= 8'd0;
         y_q          <= 8'd0;
         frame_done_q <= 1'b0;
         win_valid_q  <= 1'b0;
         win_x_q      <= 8'd0;
         win_y_q      <= 8'd0;
         for (int k = 0; k < 4; k++) begin
            win_b_q[k] <= 32'd0;
            col_q[k]   <= 24'd0;
         end
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
         win_valid_q  <= win_valid_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         for (int k = 0; k < 4; k++) begin
            win_b_q[k] <= win_b_d[k];
            col_q[k]   <= col_d[k];
         end
      end
   end

   // Line buffers roll column x up one row; contents are don't-care until refilled.
   always_ff @(posedge clk) begin
      if (take_s) begin
         lb0_q[idx_s] <= lb_rd_s[1];
         lb1_q[idx_s] <= lb_rd_s[2];
         lb2_q[idx_s] <= pix_data;
      end
   end

   assign pix_ready  = pix_ready_s;
   assign win_valid  = win_valid_q;
   assign win_b0     = win_b_q[0];
   assign win_b1     = win_b_q[1];
   assign win_b2     = win_b_q[2];
   assign win_b3     = win_b_q[3];
   assign win_x      = win_x_q;
   assign win_y      = win_y_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_img_window_feeder.sv
// Directed bench for img_window_feeder: 16x16 frames with p(x,y)=16y+x, backpressure,
// random gaps, mid-frame sof and mid-frame reset.
module tb_img_window_feeder;

   localparam int W = 16;
   localparam int H = 16;

   logic        clk = 1'b0;
   logic        rst, pix_valid, pix_ready, pix_sof, win_valid, win_ready, frame_done;
   logic [7:0]  pix_data, win_x, win_y;
   logic [31:0] win_b0, win_b1, win_b2, win_b3;

   typedef struct packed {
      logic [31:0] b0;
      logic [31:0] b1;
      logic [31:0] b2;
      logic [31:0] b3;
      logic [7:0]  x;
      logic [7:0]  y;
   } win_t;

   win_t wq[$];
   int   errors = 0;
   int   checks = 0;
   int   fd_count = 0;
   bit   rand_mode = 1'b0;
   bit   gap_mode = 1'b0;

   always #5 clk = ~clk;

   img_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_sof(pix_sof), .win_valid(win_valid),
      .win_ready(win_ready), .win_b0(win_b0), .win_b1(win_b1), .win_b2(win_b2),
      .win_b3(win_b3), .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
   );

   // Record every window taken by the consumer and every frame_done pulse.
   always @(negedge clk) begin : mon
      win_t w;
      if (!rst) begin
         if (win_valid && win_ready) begin
            w.b0 = win_b0; w.b1 = win_b1; w.b2 = win_b2; w.b3 = win_b3;
            w.x  = win_x;  w.y  = win_y;
            wq.push_back(w);
         end
         if (frame_done) fd_count++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_mode) win_ready = ($urandom_range(0, 99) >= 30);
   endtask

   task automatic send_pix(input logic [7:0] d, input logic s);
      bit done;
      int guard;
      done  = 1'b0;
      guard = 0;
      if (gap_mode) begin
         while ($urandom_range(0, 99) < 50) begin
            pix_valid = 1'b0;
            step();
         end
      end
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = s;
      while (!done) begin
         @(negedge clk);
         done = pix_ready;
         step();
         guard++;
         if (!done && guard > 2000) begin
            $display("FAIL pix_timeout: pixel %h never accepted", d);
            $fatal(1, "pixel stream stuck");
         end
      end
   endtask

   task automatic send_frame();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            send_pix(8'(16 * y + x), (x == 0) && (y == 0));
   endtask

   task automatic drain();
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      rand_mode = 1'b0;
      win_ready = 1'b1;
      repeat (6) step();
   endtask

   function automatic logic [31:0] exp_row(input int tx, input int ty, input int r);
      int x0, yy;
      x0 = 2 * tx;
      yy = 2 * ty + r;
      return {8'(16 * yy + x0), 8'(16 * yy + x0 + 1), 8'(16 * yy + x0 + 2), 8'(16 * yy + x0 + 3)};
   endfunction

   task automatic check_frame(input string tag);
      check({tag, "_nwin"}, wq.size(), 32'd49);
      check({tag, "_fdone"}, fd_count, 32'd1);
      if (wq.size() == 49) begin
         check({tag, "_w0_b0"}, wq[0].b0, 32'h00010203);
         check({tag, "_w0_b1"}, wq[0].b1, 32'h10111213);
         check({tag, "_w0_b2"}, wq[0].b2, 32'h20212223);
         check({tag, "_w0_b3"}, wq[0].b3, 32'h30313233);
         check({tag, "_w0_x"},  wq[0].x,  32'd0);
         check({tag, "_w0_y"},  wq[0].y,  32'd0);
         check({tag, "_w1_b0"}, wq[1].b0, 32'h02030405);
         check({tag, "_w1_b3"}, wq[1].b3, 32'h32333435);
         check({tag, "_w1_x"},  wq[1].x,  32'd1);
         check({tag, "_wl_b0"}, wq[48].b0, 32'hCCCDCECF);
         check({tag, "_wl_b3"}, wq[48].b3, 32'hFCFDFEFF);
         check({tag, "_wl_x"},  wq[48].x,  32'd6);
         check({tag, "_wl_y"},  wq[48].y,  32'd6);
         for (int i = 0; i < 49; i++) begin
            check({tag, "_b0"}, wq[i].b0, exp_row(i % 7, i / 7, 0));
            check({tag, "_b1"}, wq[i].b1, exp_row(i % 7, i / 7, 1));
            check({tag, "_b2"}, wq[i].b2, exp_row(i % 7, i / 7, 2));
            check({tag, "_b3"}, wq[i].b3, exp_row(i % 7, i / 7, 3));
            check({tag, "_x"},  wq[i].x,  32'(i % 7));
            check({tag, "_y"},  wq[i].y,  32'(i / 7));
         end
      end
      wq.delete();
      fd_count = 0;
   endtask

   initial begin
      logic [31:0] held;
      int g;
      rst = 1'b1; pix_valid = 1'b0; pix_data = 8'd0; pix_sof = 1'b0; win_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pix_ready", pix_ready, 32'd1);
      check("rst_win_valid", win_valid, 32'd0);
      check("rst_b0", win_b0, 32'd0);
      check("rst_b3", win_b3, 32'd0);
      check("rst_x", win_x, 32'd0);
      check("rst_y", win_y, 32'd0);
      check("rst_fdone", frame_done, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // T1/T2: clean frame, consumer always ready
      send_frame();
      drain();
      check_frame("t1");

      // T3: consumer stalls for 20 cycles at the first window
      win_ready = 1'b0;
      fork
         send_frame();
         begin
            g = 0;
            @(negedge clk);
            while (!win_valid && g < 2000) begin
               @(negedge clk);
               g++;
            end
            check("t3_first_valid", win_valid, 32'd1);
            held = win_b0;
            check("t3_first_b0", held, 32'h00010203);
            repeat (20) begin
               @(negedge clk);
               check("t3_pix_ready", pix_ready, 32'd0);
               check("t3_hold_b0", win_b0, held);
               check("t3_hold_valid", win_valid, 32'd1);
            end
            @(posedge clk); #1;
            win_ready = 1'b1;
         end
      join
      drain();
      check_frame("t3");

      // T4: random input gaps and consumer stalls
      rand_mode = 1'b1;
      gap_mode  = 1'b1;
      send_frame();
      gap_mode = 1'b0;
      drain();
      check_frame("t4");

      // T5: frame aborted by sof at (5,7), then a clean frame
      for (int i = 0; i < 7 * 16 + 5; i++) send_pix(8'(i), i == 0);
      drain();
      check("t5_partial_nwin", wq.size(), 32'd15);
      check("t5_no_fdone", fd_count, 32'd0);
      wq.delete();
      fd_count = 0;
      send_frame();
      drain();
      check_frame("t5");

      // T6: reset while a window is pending, then non-sof pixels are dropped
      win_ready = 1'b0;
      for (int i = 0; i < 3 * 16 + 4; i++) send_pix(8'(i), i == 0);
      pix_valid = 1'b0;
      @(negedge clk);
      check("t6_pre_valid", win_valid, 32'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", win_valid, 32'd0);
      check("t6_rst_ready", pix_ready, 32'd1);
      check("t6_rst_b0", win_b0, 32'd0);
      check("t6_rst_b3", win_b3, 32'd0);
      check("t6_rst_x", win_x, 32'd0);
      check("t6_rst_y", win_y, 32'd0);
      check("t6_rst_fdone", frame_done, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      win_ready = 1'b1;
      wq.delete();
      fd_count = 0;
      for (int i = 0; i < 64; i++) send_pix(8'hA5, 1'b0);
      drain();
      check("t6_dropped_nwin", wq.size(), 32'd0);
      check("t6_dropped_fdone", fd_count, 32'd0);
      wq.delete();
      send_frame();
      drain();
      check_frame("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
